// File: rtl/branch_resolve_ctrl_if.sv
// Branch-resolution controller bus bundle.
//   res_*        : branch FU -> controller resolution (valid/ready)
//   flush / redirect_* / fetch_stall : controller -> fetch stage
//   btb_wr_*     : controller -> BTB write port (valid/ready)
//   busy         : controller activity status
// Modports: slave = controller side, master = FU/fetch/BTB side.
interface branch_resolve_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              res_valid;
  logic              res_mispredict;
  logic [WORD_W-1:0] res_correct_pc;
  logic              res_update_btb;
  logic [WORD_W-1:0] res_update_pc;
  logic [WORD_W-1:0] res_branch_target;
  logic              res_ready;
  logic              flush;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              fetch_stall;
  logic              btb_wr_valid;
  logic [WORD_W-1:0] btb_wr_pc;
  logic [WORD_W-1:0] btb_wr_target;
  logic              btb_wr_ready;
  logic              busy;

  modport slave (
    input  res_valid, res_mispredict, res_correct_pc, res_update_btb,
           res_update_pc, res_branch_target, btb_wr_ready,
    output res_ready, flush, redirect_valid, redirect_pc, fetch_stall,
           btb_wr_valid, btb_wr_pc, btb_wr_target, busy
  );

  modport master (
    output res_valid, res_mispredict, res_correct_pc, res_update_btb,
           res_update_pc, res_branch_target, btb_wr_ready,
    input  res_ready, flush, redirect_valid, redirect_pc, fetch_stall,
           btb_wr_valid, btb_wr_pc, btb_wr_target, busy
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Sequences resolved-branch effects: a mispredict becomes one registered
//   flush+redirect cycle followed by FLUSH_CYCLES fetch-stall cycles; BTB
//   updates are queued in a BTBQ_DEPTH-entry FIFO drained over valid/ready.
// Ports:
//   CLK, nRST            clock (rising), async active-low reset
//   br (slave modport)   resolution input, fetch control, BTB write port, busy
//   stat_branches/stat_mispredicts  (only with BR_CTRL_STATS_EN) saturating
//                        counts of accepts / mispredicted accepts
// Optional feature macro: BR_CTRL_STATS_EN
module branch_resolve_ctrl #(
  parameter int WORD_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int BTBQ_DEPTH   = 4
) (
  input  logic CLK,
  input  logic nRST,
  branch_resolve_ctrl_if.slave br
`ifdef BR_CTRL_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int PTR_W  = $clog2(BTBQ_DEPTH);
  localparam int QCNT_W = PTR_W + 1;
  // +2 keeps the width non-zero when FLUSH_CYCLES is 0
  localparam int CNT_W  = $clog2(FLUSH_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, FLUSH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  pc_q, pc_d;

  logic [BTBQ_DEPTH-1:0][WORD_W-1:0] pc_mem_q, tgt_mem_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [QCNT_W-1:0]  qcnt_q;

  logic accept, push, pop, q_nonempty;

  assign q_nonempty = (qcnt_q != '0);
  // Gated by nRST so the FU sees not-ready while reset is held.
  assign br.res_ready = nRST && (state_q == IDLE) && (qcnt_q < QCNT_W'(BTBQ_DEPTH));
  assign accept = br.res_valid && br.res_ready;
  assign push   = accept && br.res_update_btb;
  assign pop    = q_nonempty && br.btb_wr_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (accept && br.res_mispredict) begin
          state_d = FLUSH;
          pc_d    = br.res_correct_pc;
        end
      end
      FLUSH: begin
        if (FLUSH_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign br.flush          = (state_q == FLUSH);
  assign br.redirect_valid = (state_q == FLUSH);
  assign br.redirect_pc    = (state_q == FLUSH) ? pc_q : '0;
  assign br.fetch_stall    = (state_q != IDLE);
  assign br.busy           = (state_q != IDLE) || q_nonempty;

  // ---------------- BTB update FIFO ----------------
  // Drains regardless of FSM state; a flush never drops queued updates.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_mem_q  <= '0;
      tgt_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      qcnt_q    <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]  <= br.res_update_pc;
        tgt_mem_q[wr_ptr_q] <= br.res_branch_target;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   qcnt_q <= qcnt_q + 1'b1;
        2'b01:   qcnt_q <= qcnt_q - 1'b1;
        default: qcnt_q <= qcnt_q;
      endcase
    end
  end

  assign br.btb_wr_valid  = q_nonempty;
  assign br.btb_wr_pc     = q_nonempty ? pc_mem_q[rd_ptr_q]  : '0;
  assign br.btb_wr_target = q_nonempty ? tgt_mem_q[rd_ptr_q] : '0;

`ifdef BR_CTRL_STATS_EN
  // ---------------- statistics ----------------
  logic [31:0] stat_br_q, stat_mp_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (accept && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 1'b1;
      if (accept && br.res_mispredict && (stat_mp_q != 32'hFFFF_FFFF))
        stat_mp_q <= stat_mp_q + 1'b1;
    end
  end
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  localparam int WORD_W = 32;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  branch_resolve_ctrl_if #(.WORD_W(WORD_W)) bif ();

`ifdef BR_CTRL_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_ctrl #(.WORD_W(WORD_W), .FLUSH_CYCLES(2), .BTBQ_DEPTH(4)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .br(bif.slave)
`ifdef BR_CTRL_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bif.res_valid         = 1'b0;
    bif.res_mispredict    = 1'b0;
    bif.res_correct_pc    = '0;
    bif.res_update_btb    = 1'b0;
    bif.res_update_pc     = '0;
    bif.res_branch_target = '0;
    bif.btb_wr_ready      = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bif.res_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bif.res_ready) begin
      failures++;
      $display("FAIL %s: res_ready timeout got=%0b want=1", tag, bif.res_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    bif.res_valid = 1'b1;
    bif.res_mispredict = 1'b1;
    bif.res_update_btb = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bif.res_ready, bif.flush, bif.redirect_valid, bif.fetch_stall,
         bif.btb_wr_valid, bif.busy} !== 6'b0 || bif.redirect_pc !== '0 ||
        bif.btb_wr_pc !== '0 || bif.btb_wr_target !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b fl=%b rv=%b st=%b bv=%b busy=%b rpc=%h bpc=%h want all 0",
               bif.res_ready, bif.flush, bif.redirect_valid, bif.fetch_stall,
               bif.btb_wr_valid, bif.busy, bif.redirect_pc, bif.btb_wr_pc);
    end
    bif.res_valid = 1'b0;
    bif.res_mispredict = 1'b0;
    bif.res_update_btb = 1'b0;
    #1 nRST = 1'b1;
    #1;
    checks++;
    if (bif.res_ready !== 1'b1 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", bif.res_ready, bif.busy);
    end
    tick();
  endtask

  task automatic test_mispredict();
    logic [2:0] exp_stall [0:3];
    exp_stall[0] = 1; exp_stall[1] = 1; exp_stall[2] = 1; exp_stall[3] = 0;
    bif.res_valid = 1'b1;
    bif.res_mispredict = 1'b1;
    bif.res_correct_pc = 32'h0000_1040;
    tick();
    idle_inputs();
    @(negedge CLK);
    checks++;
    if (bif.flush !== 1'b1 || bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1040 ||
        bif.res_ready !== 1'b0) begin
      failures++;
      $display("FAIL mp_flush: got fl=%b rv=%b rpc=%h rdy=%b want 1 1 00001040 0",
               bif.flush, bif.redirect_valid, bif.redirect_pc, bif.res_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.fetch_stall !== exp_stall[i][0] || bif.res_ready !== ~exp_stall[i][0] ||
          (i > 0 && (bif.flush !== 1'b0 || bif.redirect_valid !== 1'b0))) begin
        failures++;
        $display("FAIL mp_stall[%0d]: got st=%b rdy=%b fl=%b rv=%b want st=%b rdy=%b",
                 i, bif.fetch_stall, bif.res_ready, bif.flush, bif.redirect_valid,
                 exp_stall[i][0], ~exp_stall[i][0]);
      end
      @(negedge CLK);
    end
    checks++;
    if (bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL mp_busy_end: got=%b want=0", bif.busy);
    end
    // correctly predicted accept: no flush, no stall
    #4 bif.res_valid = 1'b1;
    bif.res_correct_pc = 32'hDEAD_0000;
    tick();
    idle_inputs();
    checks++;
    if (bif.flush !== 1'b0 || bif.fetch_stall !== 1'b0 || bif.res_ready !== 1'b1) begin
      failures++;
      $display("FAIL correct_pred: got fl=%b st=%b rdy=%b want 0 0 1",
               bif.flush, bif.fetch_stall, bif.res_ready);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_pc [0:4];
    logic acc;
    for (int i = 0; i < 5; i++) exp_pc[i] = 32'h100 + 4 * i;
    bif.btb_wr_ready = 1'b0;
    checks++;
    if (bif.btb_wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ff_empty: btb_wr_valid got=%b want=0", bif.btb_wr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      bif.res_valid = 1'b1;
      bif.res_update_btb = 1'b1;
      bif.res_update_pc = exp_pc[i];
      bif.res_branch_target = 32'h2000 + i;
      tick();
    end
    // fifth held by the FU
    bif.res_update_pc = exp_pc[4];
    bif.res_branch_target = 32'h2004;
    tick();
    checks++;
    if (bif.res_ready !== 1'b0 || bif.btb_wr_valid !== 1'b1 || bif.btb_wr_pc !== 32'h100 ||
        bif.btb_wr_target !== 32'h2000 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL ff_full: got rdy=%b bv=%b pc=%h tgt=%h busy=%b want 0 1 00000100 00002000 1",
               bif.res_ready, bif.btb_wr_valid, bif.btb_wr_pc, bif.btb_wr_target, bif.busy);
    end
    bif.btb_wr_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bif.btb_wr_valid !== 1'b1 || bif.btb_wr_pc !== exp_pc[j] ||
          bif.btb_wr_target !== 32'h2000 + j) begin
        failures++;
        $display("FAIL ff_drain[%0d]: got v=%b pc=%h tgt=%h want 1 %h %h",
                 j, bif.btb_wr_valid, bif.btb_wr_pc, bif.btb_wr_target, exp_pc[j], 32'h2000 + j);
      end
      acc = bif.res_valid && bif.res_ready;
      tick();
      if (acc) begin
        bif.res_valid = 1'b0;
        bif.res_update_btb = 1'b0;
      end
    end
    checks++;
    if (bif.btb_wr_valid !== 1'b0 || bif.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL ff_after: got bv=%b fu_valid=%b want 0 0", bif.btb_wr_valid, bif.res_valid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bif.btb_wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.res_valid = 1'b1;
      bif.res_update_btb = 1'b1;
      bif.res_update_pc = 32'h300 + 4 * i;
      bif.res_branch_target = 32'h3100 + i;
      tick();
    end
    bif.res_update_pc = 32'h308;
    bif.res_branch_target = 32'h3102;
    bif.btb_wr_ready = 1'b1;
    checks++;
    if (bif.btb_wr_pc !== 32'h300) begin
      failures++;
      $display("FAIL bb_head_before: got=%h want=00000300", bif.btb_wr_pc);
    end
    tick();
    bif.res_valid = 1'b0;
    bif.res_update_btb = 1'b0;
    bif.btb_wr_ready = 1'b0;
    checks++;
    if (bif.btb_wr_pc !== 32'h304 || bif.btb_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL bb_head_after: got v=%b pc=%h want 1 00000304", bif.btb_wr_valid, bif.btb_wr_pc);
    end
    // drain the remaining two to prove count stayed 2
    bif.btb_wr_ready = 1'b1;
    tick();
    checks++;
    if (bif.btb_wr_pc !== 32'h308 || bif.btb_wr_target !== 32'h3102) begin
      failures++;
      $display("FAIL bb_tail: got pc=%h tgt=%h want 00000308 00003102", bif.btb_wr_pc, bif.btb_wr_target);
    end
    tick();
    checks++;
    if (bif.btb_wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL bb_count: btb_wr_valid got=%b want=0", bif.btb_wr_valid);
    end
    idle_inputs();
  endtask

  task automatic test_drain_in_flush();
    bif.res_valid = 1'b1;
    bif.res_mispredict = 1'b1;
    bif.res_correct_pc = 32'h600;
    bif.res_update_btb = 1'b1;
    bif.res_update_pc = 32'h500;
    bif.res_branch_target = 32'h5500;
    tick();
    idle_inputs();
    checks++;
    if (bif.flush !== 1'b1 || bif.btb_wr_valid !== 1'b1 || bif.btb_wr_pc !== 32'h500) begin
      failures++;
      $display("FAIL df_flush: got fl=%b bv=%b pc=%h want 1 1 00000500", bif.flush, bif.btb_wr_valid, bif.btb_wr_pc);
    end
    bif.btb_wr_ready = 1'b1;
    tick();
    checks++;
    if (bif.btb_wr_valid !== 1'b0 || bif.fetch_stall !== 1'b1 || bif.flush !== 1'b0) begin
      failures++;
      $display("FAIL df_hold: got bv=%b st=%b fl=%b want 0 1 0", bif.btb_wr_valid, bif.fetch_stall, bif.flush);
    end
    idle_inputs();
    wait_ready("df_end");
  endtask

  task automatic test_reset_hold();
    int seen_redirect = 0;
    bif.res_valid = 1'b1;
    bif.res_mispredict = 1'b1;
    bif.res_correct_pc = 32'h700;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bif.fetch_stall !== 1'b1 || bif.flush !== 1'b0) begin
      failures++;
      $display("FAIL rh_in_hold: got st=%b fl=%b want 1 0", bif.fetch_stall, bif.flush);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (bif.fetch_stall !== 1'b0 || bif.res_ready !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL rh_async: got st=%b rdy=%b busy=%b want 0 0 0", bif.fetch_stall, bif.res_ready, bif.busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (bif.redirect_valid || bif.flush || bif.fetch_stall) seen_redirect++;
    end
    checks++;
    if (seen_redirect != 0 || bif.res_ready !== 1'b1) begin
      failures++;
      $display("FAIL rh_no_replay: got redirect_cycles=%0d rdy=%b want 0 1", seen_redirect, bif.res_ready);
    end
    #4;
  endtask

`ifdef BR_CTRL_STATS_EN
  task automatic test_stats();
    logic [4:0] mp;
    mp = 5'b01010;
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL st_reset: got br=%0d mp=%0d want 0 0", stat_branches, stat_mispredicts);
    end
    for (int i = 0; i < 5; i++) begin
      wait_ready("st_wait");
      bif.res_valid = 1'b1;
      bif.res_mispredict = mp[i];
      bif.res_correct_pc = 32'h900 + 4 * i;
      tick();
      idle_inputs();
    end
    wait_ready("st_final");
    checks++;
    if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
      failures++;
      $display("FAIL st_counts: got br=%0d mp=%0d want 5 2", stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mispredict();
    test_fifo_full();
    test_back_to_back();
    test_drain_in_flush();
    test_reset_hold();
`ifdef BR_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
